// File: rtl/rom_access_arbiter_pkg.sv
// Shared types and constants for the ROM access arbiter.
package rom_access_arbiter_pkg;

  typedef enum logic [2:0] {
    RESYNC,
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic        RESP_ID_FETCH = 1'b0;
  localparam logic        RESP_ID_LOAD  = 1'b1;
  localparam logic [31:0] ERR_DATA      = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_2phase.sv
// Multi-flop synchronizer for the asynchronous two-phase ROM ack; resets to 0.
module sync_2phase #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) sr_p0 <= '0;
    else        sr_p0 <= {sr_p0[STAGES-2:0], d};
  end

  assign q = sr_p0[STAGES-1];

endmodule

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing a byte-wide two-phase ROM between fetch and load,
// assembling 1 or 4 bytes little-endian into a 32-bit response.
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  input  logic        l_req,
  input  logic [31:0] l_addr,
  input  logic        l_byte,
  output logic        l_gnt,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] rom_addr,
  output logic        rom_trigger,
  input  logic [7:0]  rom_data,
  input  logic        rom_ready
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SETTLE   = 8'(SYNC_STAGES);

  state_t      state, state_nx;
  logic        rdy_s;
  logic        match;
  logic        settled;
  logic [7:0]  tcnt;
  logic [1:0]  k;
  logic        is_byte;
  logic        cur_id;
  logic        last_l;
  logic        err;
  logic [31:0] base;
  logic [31:0] asm_q;

  sync_2phase #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rom_ready),
    .q     (rdy_s)
  );

  assign match = (rdy_s == rom_trigger);
  // After reset the synchronizer holds 0, not the real ack level, until it refills.
  assign settled = (tcnt >= SETTLE);

  always_comb begin
    state_nx = state;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    case (state)
      RESYNC: if (settled && (match || tcnt >= TMO_LAST)) state_nx = IDLE;
      IDLE: begin
        if (f_req && (!l_req || last_l)) begin
          f_gnt    = 1'b1;
          state_nx = ISSUE;
        end else if (l_req) begin
          l_gnt    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (match)                 state_nx = (is_byte || k == 2'd3) ? DONE : ISSUE;
        else if (tcnt == TMO_LAST) state_nx = DONE;
      end
      DONE:    state_nx = err ? RESYNC : IDLE;
      default: state_nx = RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RESYNC;
      tcnt        <= '0;
      k           <= '0;
      is_byte     <= 1'b0;
      cur_id      <= RESP_ID_FETCH;
      last_l      <= 1'b1;
      err         <= 1'b0;
      rom_addr    <= '0;
      rom_trigger <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        RESYNC: begin
          tcnt <= tcnt + 8'd1;
          if (settled && !match && tcnt >= TMO_LAST) rom_trigger <= rdy_s;
        end
        IDLE: begin
          tcnt <= '0;
          k    <= '0;
          err  <= 1'b0;
          if (f_gnt) begin
            is_byte <= 1'b0;
            cur_id  <= RESP_ID_FETCH;
            last_l  <= 1'b0;
          end else if (l_gnt) begin
            is_byte <= l_byte;
            cur_id  <= RESP_ID_LOAD;
            last_l  <= 1'b1;
          end
        end
        ISSUE: begin
          tcnt        <= '0;
          rom_addr    <= base + {30'd0, k};
          rom_trigger <= ~rom_trigger;
        end
        WAIT: begin
          tcnt <= tcnt + 8'd1;
          if (match)                 k   <= k + 2'd1;
          else if (tcnt == TMO_LAST) err <= 1'b1;
        end
        DONE:    tcnt <= '0;
        default: ;
      endcase
    end
  end

  // Byte assembly; only meaningful between grant and DONE, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      base  <= l_gnt ? l_addr : f_addr;
      asm_q <= '0;
    end else if (state == WAIT && match) begin
      asm_q[{k, 3'b000} +: 8] <= rom_data;
    end
  end

  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign resp_id    = resp_valid & cur_id;
  assign resp_err   = resp_valid & err;
  assign resp_data  = !resp_valid ? 32'd0 : (err ? ERR_DATA : asm_q);

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter with a zero-latency two-phase ROM model.
`timescale 1ns/1ps
module tb_rom_access_arbiter;

  localparam int SYNC = 2;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0, l_req = 1'b0, l_byte = 1'b0;
  logic [31:0] f_addr = '0, l_addr = '0;
  logic        f_gnt, l_gnt, resp_valid, resp_id, resp_err, busy, rom_trigger;
  logic [31:0] resp_data, rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ready = 1'b0;
  logic        rom_alive = 1'b1;

  always #5 clk = ~clk;

  rom_access_arbiter #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .l_req(l_req), .l_addr(l_addr), .l_byte(l_byte), .l_gnt(l_gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .rom_addr(rom_addr), .rom_trigger(rom_trigger),
    .rom_data(rom_data), .rom_ready(rom_ready)
  );

  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    case (a)
      32'h100: rom_byte = 8'h11;
      32'h101: rom_byte = 8'h22;
      32'h102: rom_byte = 8'h33;
      32'h103: rom_byte = 8'h44;
      32'h007: rom_byte = 8'hA5;
      default: rom_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  assign rom_data = rom_byte(rom_addr);
  always @(rom_trigger or rom_alive) if (rom_alive) rom_ready = rom_trigger;

  // Event logs filled on the falling edge
  logic [31:0] addr_log[$];
  logic        gnt_log[$];
  logic [33:0] resp_log[$];
  int cyc = 0, gnt_cyc = 0, resp_cyc = 0;
  logic trig_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rom_trigger != trig_prev) addr_log.push_back(rom_addr);
    trig_prev = rom_trigger;
    if (f_gnt) begin gnt_log.push_back(1'b0); gnt_cyc = cyc; end
    if (l_gnt) begin gnt_log.push_back(1'b1); gnt_cyc = cyc; end
    if (resp_valid) begin resp_log.push_back({resp_err, resp_id, resp_data}); resp_cyc = cyc; end
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic bound_fail(input string nm);
    n_total++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic clear_logs();
    addr_log.delete();
    gnt_log.delete();
    resp_log.delete();
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input logic ld, input logic bt, input logic [31:0] addr, input string nm);
    int t;
    @(posedge clk); #1;
    if (ld) begin l_req = 1'b1; l_addr = addr; l_byte = bt; end
    else    begin f_req = 1'b1; f_addr = addr; end
    t = 0;
    do begin @(negedge clk); t++; end while (!(ld ? l_gnt : f_gnt) && t < 400);
    if (t >= 400) bound_fail(nm);
    @(posedge clk); #1;
    f_req = 1'b0;
    l_req = 1'b0;
  endtask

  task automatic wait_resp(input int n, input string nm);
    int t;
    t = 0;
    while (resp_log.size() < n && t < 400) begin @(negedge clk); t++; end
    if (resp_log.size() < n) bound_fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 400);
    if (busy) bound_fail(nm);
  endtask

  typedef struct {
    logic        ld;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] data;
    int          ntog;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t;
    int n;
    logic [31:0] ea;
    logic        eg[3];

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h4433_2211, 4};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_00A5, 1};
    vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 32'h5B5A_A5A4, 4};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h5958_5B5A, 4};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0103, 32'h0000_0044, 1};

    // Reset state
    do_reset(3);
    @(negedge clk);
    chk("rst_f_gnt", 32'(f_gnt), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_trigger", 32'(rom_trigger), 32'd0);
    chk("rst_addr", rom_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    wait_idle("rst_idle");

    // Single transactions
    for (int i = 0; i < 5; i++) begin
      clear_logs();
      issue(vecs[i].ld, vecs[i].bt, vecs[i].addr, $sformatf("v%0d_gnt", i));
      wait_resp(1, $sformatf("v%0d_resp", i));
      if (resp_log.size() > 0) begin
        chk($sformatf("v%0d_data", i), resp_log[0][31:0], vecs[i].data);
        chk($sformatf("v%0d_id", i), 32'(resp_log[0][32]), 32'(vecs[i].ld));
        chk($sformatf("v%0d_err", i), 32'(resp_log[0][33]), 32'd0);
      end
      chk($sformatf("v%0d_ntog", i), 32'(addr_log.size()), 32'(vecs[i].ntog));
      if (addr_log.size() > 0) chk($sformatf("v%0d_addr0", i), addr_log[0], vecs[i].addr);
      if (i == 0) chk("word_latency", 32'(resp_cyc - gnt_cyc), 32'd17);
      if (i == 2)
        for (int j = 1; j < addr_log.size(); j++)
          chk($sformatf("wrap_addr%0d", j), addr_log[j], vecs[i].addr + 32'(j));
      wait_idle($sformatf("v%0d_idle", i));
    end

    // Contention: both requesting continuously for three grants
    clear_logs();
    @(posedge clk); #1;
    f_addr = 32'h300; l_addr = 32'h404; l_byte = 1'b0;
    f_req = 1'b1; l_req = 1'b1;
    t = 0;
    while (gnt_log.size() < 3 && t < 400) begin @(negedge clk); t++; end
    if (gnt_log.size() < 3) bound_fail("arb_grants");
    @(posedge clk); #1;
    f_req = 1'b0; l_req = 1'b0;
    wait_resp(3, "arb_resp");
    eg[0] = 1'b0; eg[1] = 1'b1; eg[2] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (gnt_log.size() > j) chk($sformatf("arb_gnt%0d", j), 32'(gnt_log[j]), 32'(eg[j]));
      if (resp_log.size() > j) begin
        chk($sformatf("arb_id%0d", j), 32'(resp_log[j][32]), 32'(eg[j]));
        chk($sformatf("arb_data%0d", j), resp_log[j][31:0], eg[j] ? 32'h5D5C_5F5E : 32'h5958_5B5A);
      end
    end
    chk("arb_ntog", 32'(addr_log.size()), 32'd12);
    for (int j = 0; j < addr_log.size(); j++) begin
      ea = ((j / 4) == 1) ? 32'h404 : 32'h300;
      chk($sformatf("arb_addr%0d", j), addr_log[j], ea + 32'(j % 4));
    end
    wait_idle("arb_idle");

    // ROM never acks: timeout, then realignment and a normal transfer
    clear_logs();
    rom_alive = 1'b0;
    issue(1'b0, 1'b0, 32'h500, "tmo_gnt");
    wait_resp(1, "tmo_resp");
    if (resp_log.size() > 0) begin
      chk("tmo_err", 32'(resp_log[0][33]), 32'd1);
      chk("tmo_data", resp_log[0][31:0], 32'hFFFF_FFFF);
      chk("tmo_id", 32'(resp_log[0][32]), 32'd0);
    end
    chk("tmo_latency", 32'(resp_cyc - gnt_cyc), 32'(TMO + 2));
    chk("tmo_ntog", 32'(addr_log.size()), 32'd1);
    wait_idle("tmo_idle");
    chk("tmo_realign", 32'(rom_trigger), 32'(rom_ready));
    clear_logs();
    rom_alive = 1'b1;
    issue(1'b1, 1'b1, 32'h7, "post_tmo_gnt");
    wait_resp(1, "post_tmo_resp");
    if (resp_log.size() > 0) begin
      chk("post_tmo_data", resp_log[0][31:0], 32'h0000_00A5);
      chk("post_tmo_err", 32'(resp_log[0][33]), 32'd0);
    end
    wait_idle("post_tmo_idle");

    // Reset mid-WAIT while the ROM still owes an ack
    do_reset(1);
    wait_idle("mr_pre_idle");
    clear_logs();
    issue(1'b0, 1'b0, 32'h100, "mr_gnt0");
    t = 0;
    while (addr_log.size() < 1 && t < 100) begin @(negedge clk); t++; end
    rom_alive = 1'b0;
    while (addr_log.size() < 2 && t < 100) begin @(negedge clk); t++; end
    if (addr_log.size() < 2) bound_fail("mr_byte1");
    do_reset(1);
    f_addr = 32'h100;
    f_req  = 1'b1;
    clear_logs();
    @(negedge clk);
    chk("mr_rst_trigger", 32'(rom_trigger), 32'd0);
    chk("mr_rst_addr", rom_addr, 32'd0);
    chk("mr_nogrant0", 32'(f_gnt), 32'd0);
    repeat (2) @(negedge clk);
    chk("mr_nogrant1", 32'(f_gnt), 32'd0);
    rom_alive = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_gnt && n < 400);
    if (!f_gnt) bound_fail("mr_gnt1");
    chk("mr_gnt_delay", 32'(n), 32'(SYNC + 1));
    @(posedge clk); #1 f_req = 1'b0;
    wait_resp(1, "mr_resp");
    if (resp_log.size() > 0) chk("mr_data", resp_log[0][31:0], 32'h4433_2211);
    repeat (5) @(negedge clk);
    chk("mr_resp_count", 32'(resp_log.size()), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
